// File: rtl/verifier_layer_driver.sv
// Sumcheck verifier driving one layer's prover: checks H(0)+H(1) against the running claim,
// collects a challenge, folds the claim by Horner evaluation, and advances the prover each round.
module verifier_layer_driver #(
  parameter int ninputs   = 16,
  parameter int ngates    = 16,
  parameter int layer_num = 0,
  localparam int F_NBITS  = 61,
  localparam int ninbits  = $clog2(ninputs),
  localparam int nrounds  = 2 * ninbits,
  localparam int nhpoints = ninbits + 1
) (
  input  logic                              clk,
  input  logic                              rstb,
  input  logic                              en,
  input  logic [F_NBITS-1:0]                claim_in,
  input  logic                              layer_ready_pulse,
  input  logic [1:0]                        layer_ready_code,
  input  logic [nhpoints-1:0][F_NBITS-1:0]  layer_data,
  input  logic [F_NBITS-1:0]                tau_in,
  input  logic                              tau_valid,
  output logic                              tau_ack,
  output logic                              en_layer,
  output logic                              restart_layer,
  output logic [F_NBITS-1:0]                tau,
  output logic [F_NBITS-1:0]                claim_out,
  output logic                              ready_pulse,
  output logic                              ready,
  output logic                              pass,
  output logic [2:0]                        state_dbg,
  output logic [31:0]                       layer_id,
  output logic [31:0]                       layer_gates
);

  // Handshakes: tau_valid/tau_ack transfer tau_in exactly in a cycle where both are high
  // (tau_ack only ever rises in WAIT_T); en_layer and layer_ready_pulse are single-cycle events.

  localparam logic [F_NBITS-1:0] P = {F_NBITS{1'b1}};
  localparam int rbits = $clog2(nrounds + 1);
  localparam int kbits = $clog2(nhpoints);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    KICK   = 3'd1,
    WAIT_P = 3'd2,
    CHECK  = 3'd3,
    EVAL   = 3'd4,
    WAIT_T = 3'd5,
    ISSUE  = 3'd6,
    DONE   = 3'd7
  } state_t;

  state_t state, next_state;

  logic [F_NBITS-1:0]               claim;
  logic [F_NBITS-1:0]               acc;
  logic [rbits-1:0]                 round;
  logic [kbits-1:0]                 k;
  logic [nhpoints-1:0][F_NBITS-1:0] coef;
  logic [F_NBITS-1:0]               h01;
  logic [F_NBITS-1:0]               horner;

  function automatic logic [F_NBITS-1:0] fadd(input logic [F_NBITS-1:0] a,
                                               input logic [F_NBITS-1:0] b);
    logic [F_NBITS:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, P}) s = s - {1'b0, P};
    return s[F_NBITS-1:0];
  endfunction

  // Mersenne fold: 2^61 == 1 mod p, so the high half adds onto the low half.
  function automatic logic [F_NBITS-1:0] fmul(input logic [F_NBITS-1:0] a,
                                               input logic [F_NBITS-1:0] b);
    logic [2*F_NBITS-1:0] m;
    logic [F_NBITS:0]     s;
    m = {{F_NBITS{1'b0}}, a} * {{F_NBITS{1'b0}}, b};
    s = {1'b0, m[F_NBITS-1:0]} + {1'b0, m[2*F_NBITS-1:F_NBITS]};
    if (s >= {1'b0, P}) s = s - {1'b0, P};
    return s[F_NBITS-1:0];
  endfunction

  always_comb begin
    h01 = fadd(coef[0], coef[0]);
    for (int i = 1; i < nhpoints; i++) h01 = fadd(h01, coef[i]);
  end

  assign horner = fadd(fmul(acc, tau), coef[k]);

  always_comb begin
    next_state = state;
    case (state)
      IDLE:   if (en) next_state = KICK;
      KICK:   next_state = WAIT_P;
      WAIT_P: if (layer_ready_pulse) begin
                if (layer_ready_code == 2'b00 && round < rbits'(nrounds)) next_state = CHECK;
                else next_state = DONE;
              end
      CHECK:  next_state = (h01 == claim) ? WAIT_T : DONE;
      WAIT_T: if (tau_valid) next_state = EVAL;
      EVAL:   if (k == '0) next_state = ISSUE;
      ISSUE:  next_state = WAIT_P;
      DONE:   if (en) next_state = KICK;
      default: next_state = IDLE;
    endcase
  end

  assign en_layer      = (state == KICK) || (state == ISSUE);
  assign restart_layer = (state == KICK);
  assign tau_ack       = (state == WAIT_T) && tau_valid;
  assign claim_out     = claim;
  assign state_dbg     = state;
  assign layer_id      = 32'(layer_num);
  assign layer_gates   = 32'(ngates);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state       <= IDLE;
      claim       <= '0;
      acc         <= '0;
      round       <= '0;
      k           <= '0;
      coef        <= '0;
      tau         <= '0;
      ready       <= 1'b0;
      ready_pulse <= 1'b0;
      pass        <= 1'b0;
    end else begin
      state       <= next_state;
      ready_pulse <= 1'b0;
      if (next_state == DONE && state != DONE) begin
        ready       <= 1'b1;
        ready_pulse <= 1'b1;
      end
      case (state)
        IDLE, DONE: if (en) begin
                      claim <= claim_in;
                      round <= '0;
                      ready <= 1'b0;
                      pass  <= 1'b0;
                    end
        WAIT_P: if (layer_ready_pulse) begin
                  coef <= layer_data;
                  if (layer_ready_code == 2'b01 && round == rbits'(nrounds)) pass <= 1'b1;
                end
        WAIT_T: if (tau_valid) begin
                  tau <= tau_in;
                  acc <= coef[nhpoints-1];
                  k   <= kbits'(nhpoints - 2);
                end
        EVAL:   if (k == '0) claim <= horner;
                else begin
                  acc <= horner;
                  k   <= k - 1'b1;
                end
        ISSUE:  round <= round + 1'b1;
        default: ;
      endcase
    end
  end

endmodule
